// File: rtl/timer_multi_pkg.sv
// Shared constants for the multi-channel timer: register map, CTRL bit positions,
// channel stride and a byte-enable merge helper.
package timer_multi_pkg;

   localparam logic [3:0] OFF_CTRL   = 4'h0;
   localparam logic [3:0] OFF_LOAD   = 4'h4;
   localparam logic [3:0] OFF_COUNT  = 4'h8;
   localparam logic [3:0] OFF_STATUS = 4'hC;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE    = 1;
   localparam int CTRL_IE      = 2;
   localparam int CTRL_PSC_LSB = 16;
   localparam int STATUS_PEND  = 0;

   localparam int CH_STRIDE = 16;
   localparam int CH_SHIFT  = $clog2(CH_STRIDE);

   function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                            input logic [31:0] wdata,
                                            input logic [3:0]  be);
      logic [31:0] r;
      r = old_val;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/timer_multi_ch.sv
// One timer channel: CTRL/LOAD/COUNT/PEND state, prescaler and tick/expiry logic.
// The prescaler exists only when TIMER_MULTI_PSC_EN is defined; otherwise every EN cycle ticks.
module timer_multi_ch
   import timer_multi_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int PSC_W = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wr_ctrl,
   input  logic        wr_load,
   input  logic        clr_pend,
   input  logic [3:0]  be,
   input  logic [31:0] wdata,
   output logic [31:0] ctrl_val,
   output logic [31:0] load_val,
   output logic [31:0] count_val,
   output logic [31:0] status_val,
   output logic        irq_req
);

   logic             en;
   logic             mode;
   logic             ie;
   logic             pend;
   logic [CNT_W-1:0] load;
   logic [CNT_W-1:0] count;
   logic [31:0]      ctrl_wr;
   logic [31:0]      load_wr;
   logic [PSC_W-1:0] psc_val;
   logic             tick;
   logic             expire;
   logic             en_rise;
   logic             unused_bits;

   assign ctrl_wr = be_merge(ctrl_val, wdata, be);
   assign load_wr = be_merge(32'(load), wdata, be);
   assign en_rise = wr_ctrl && !en && ctrl_wr[CTRL_EN];
   assign expire  = tick && (count == '0);

`ifdef TIMER_MULTI_PSC_EN
   logic [PSC_W-1:0] psc;
   logic [PSC_W-1:0] presc;

   assign tick    = en && (presc == psc);
   assign psc_val = psc;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         psc   <= '0;
         presc <= '0;
      end else begin
         if (wr_ctrl) psc <= ctrl_wr[CTRL_PSC_LSB +: PSC_W];
         if (en_rise) presc <= '0;
         else if (en) presc <= (presc == psc) ? '0 : presc + PSC_W'(1);
      end
   end
`else
   assign tick    = en;
   assign psc_val = '0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         en    <= 1'b0;
         mode  <= 1'b0;
         ie    <= 1'b0;
         pend  <= 1'b0;
         load  <= '0;
         count <= '0;
      end else begin
         if (wr_ctrl) begin
            en   <= ctrl_wr[CTRL_EN];
            mode <= ctrl_wr[CTRL_MODE];
            ie   <= ctrl_wr[CTRL_IE];
         end
         // One-shot expiry overrides any simultaneous EN write
         if (expire && mode) en <= 1'b0;
         if (wr_load) load <= load_wr[CNT_W-1:0];
         if (en_rise) begin
            count <= load;
         end else if (tick) begin
            if (count != '0) count <= count - CNT_W'(1);
            else if (!mode)  count <= load;
         end
         if (expire)        pend <= 1'b1;
         else if (clr_pend) pend <= 1'b0;
      end
   end

   assign ctrl_val    = 32'({psc_val, 13'b0, ie, mode, en});
   assign load_val    = 32'(load);
   assign count_val   = 32'(count);
   assign status_val  = {31'b0, pend};
   assign irq_req     = pend && ie;
   assign unused_bits = ^{ctrl_wr, load_wr};

endmodule

// File: rtl/timer_multi.sv
// Multi-channel timer with OBI slave port: address decode, read mux, IRQ registers.
// Prescaler support inside each channel is enabled by defining TIMER_MULTI_PSC_EN.
module timer_multi
   import timer_multi_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 32,
   parameter int PSC_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [3:0]        be_i,
   input  logic [31:0]       addr_i,
   input  logic [31:0]       data_i,
   output logic              gnt_o,
   output logic              rvalid_o,
   output logic [31:0]       data_o,
   output logic [NUM_CH-1:0] irq_ch_o,
   output logic              irq_o
);

   logic [15-CH_SHIFT:0] sel_ch;
   logic [CH_SHIFT-1:0]  off;
   logic                 ch_hit;
   logic                 wr_en;
   logic [31:0]          rdata;
   logic [31:0]          ctrl_val   [NUM_CH];
   logic [31:0]          load_val   [NUM_CH];
   logic [31:0]          count_val  [NUM_CH];
   logic [31:0]          status_val [NUM_CH];
   logic [NUM_CH-1:0]    irq_req;
   logic                 unused_addr;

   assign sel_ch      = addr_i[15:CH_SHIFT];
   assign off         = addr_i[CH_SHIFT-1:0];
   assign ch_hit      = 32'(sel_ch) < 32'(NUM_CH);
   assign wr_en       = req_i && we_i && ch_hit;
   assign gnt_o       = req_i;
   assign unused_addr = ^addr_i[31:16];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic ch_wr;
      assign ch_wr = wr_en && (32'(sel_ch) == 32'(g));

      timer_multi_ch #(
         .CNT_W (CNT_W),
         .PSC_W (PSC_W)
      ) u_ch (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .wr_ctrl    (ch_wr && (off == OFF_CTRL)),
         .wr_load    (ch_wr && (off == OFF_LOAD)),
         .clr_pend   (ch_wr && (off == OFF_STATUS) && be_i[0] && data_i[STATUS_PEND]),
         .be         (be_i),
         .wdata      (data_i),
         .ctrl_val   (ctrl_val[g]),
         .load_val   (load_val[g]),
         .count_val  (count_val[g]),
         .status_val (status_val[g]),
         .irq_req    (irq_req[g])
      );
   end

   // Channels beyond NUM_CH never match, so they fall through to zero
   always_comb begin
      rdata = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         if (32'(sel_ch) == 32'(n)) begin
            case (off)
               OFF_CTRL:   rdata = ctrl_val[n];
               OFF_LOAD:   rdata = load_val[n];
               OFF_COUNT:  rdata = count_val[n];
               OFF_STATUS: rdata = status_val[n];
               default:    rdata = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rvalid_o <= 1'b0;
         data_o   <= '0;
         irq_ch_o <= '0;
         irq_o    <= 1'b0;
      end else begin
         rvalid_o <= req_i;
         data_o   <= (req_i && !we_i) ? rdata : '0;
         irq_ch_o <= irq_req;
         irq_o    <= |irq_req;
      end
   end

endmodule

// File: tb/tb_timer_multi.sv
// Directed self-checking bench for timer_multi: register-access vector table plus
// hand-timed sequences for expiry, W1C races, one-shot, freeze and async reset.
module tb_timer_multi;

`ifdef TIMER_MULTI_PSC_EN
   localparam bit PSC_ON = 1'b1;
`else
   localparam bit PSC_ON = 1'b0;
`endif

   logic        clk_i  = 1'b0;
   logic        rst_i  = 1'b1;
   logic        req_i  = 1'b0;
   logic        we_i   = 1'b0;
   logic [3:0]  be_i   = 4'h0;
   logic [31:0] addr_i = 32'h0;
   logic [31:0] data_i = 32'h0;
   logic        gnt_o;
   logic        rvalid_o;
   logic [31:0] data_o;
   logic [3:0]  irq_ch_o;
   logic        irq_o;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] last_rdata;

   timer_multi #(.NUM_CH(4), .CNT_W(32), .PSC_W(16)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    (req_i),
      .we_i     (we_i),
      .be_i     (be_i),
      .addr_i   (addr_i),
      .data_i   (data_i),
      .gnt_o    (gnt_o),
      .rvalid_o (rvalid_o),
      .data_o   (data_o),
      .irq_ch_o (irq_ch_o),
      .irq_o    (irq_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   // Called #1 after a rising edge; consumes exactly one edge.
   task automatic bus_xfer(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata);
      req_i  = 1'b1;
      we_i   = we;
      addr_i = addr;
      be_i   = be;
      data_i = wdata;
      @(negedge clk_i);
      check("gnt", {31'b0, gnt_o}, 32'd1);
      @(posedge clk_i);
      #1;
      req_i  = 1'b0;
      we_i   = 1'b0;
      be_i   = 4'h0;
      data_i = 32'h0;
      check("rvalid", {31'b0, rvalid_o}, 32'd1);
      last_rdata = data_o;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      bus_xfer(1'b1, addr, 4'hF, data);
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
      bus_xfer(1'b0, addr, 4'hF, 32'h0);
      check(name, last_rdata, exp);
   endtask

   // Reads STATUS every cycle after an enabling write; PEND set on edge x shows on read x+1.
   task automatic expect_expiry(input logic [31:0] status_addr, input int x, input int n,
                                input string name);
      for (int k = 1; k <= n; k++) begin
         rd(status_addr, (k >= x + 1) ? 32'd1 : 32'd0, name);
      end
   endtask

   initial begin
      vecs[0]  = '{1'b1, 32'h34,    4'hF, 32'hFFFF_FFFF, 32'h0};
      vecs[1]  = '{1'b0, 32'h34,    4'hF, 32'h0,         32'hFFFF_FFFF};
      vecs[2]  = '{1'b1, 32'h34,    4'h1, 32'h1234_5678, 32'h0};
      vecs[3]  = '{1'b0, 32'h34,    4'hF, 32'h0,         32'hFFFF_FF78};
      vecs[4]  = '{1'b1, 32'h34,    4'h6, 32'hAABB_CCDD, 32'h0};
      vecs[5]  = '{1'b0, 32'h34,    4'hF, 32'h0,         32'hFFBB_CC78};
      vecs[6]  = '{1'b1, 32'h30,    4'hF, 32'h0007_0006, 32'h0};
      vecs[7]  = '{1'b0, 32'h30,    4'hF, 32'h0,         PSC_ON ? 32'h0007_0006 : 32'h6};
      vecs[8]  = '{1'b1, 32'h30,    4'h1, 32'hFFFF_FFF8, 32'h0};
      vecs[9]  = '{1'b0, 32'h30,    4'hF, 32'h0,         PSC_ON ? 32'h0007_0000 : 32'h0};
      vecs[10] = '{1'b0, 32'h40,    4'hF, 32'h0,         32'h0};
      vecs[11] = '{1'b1, 32'h44,    4'hF, 32'hFFFF_FFFF, 32'h0};
      vecs[12] = '{1'b0, 32'h44,    4'hF, 32'h0,         32'h0};
      vecs[13] = '{1'b0, 32'h03,    4'hF, 32'h0,         32'h0};
      vecs[14] = '{1'b1, 32'h38,    4'hF, 32'h0000_0055, 32'h0};
      vecs[15] = '{1'b0, 32'h38,    4'hF, 32'h0,         32'h0};
      vecs[16] = '{1'b0, 32'h1_0034, 4'hF, 32'h0,        32'hFFBB_CC78};

      // Reset state
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_rvalid", {31'b0, rvalid_o}, 32'd0);
      check("rst_irq", {31'b0, irq_o}, 32'd0);
      rst_i = 1'b0;
      for (int a = 0; a < 64; a += 4) rd(32'(a), 32'h0, "rst_reg");
      idle(1);
      check("idle_rvalid", {31'b0, rvalid_o}, 32'd0);

      // Register access table on channel 3 and unmapped space
      for (int i = 0; i < 17; i++) begin
         bus_xfer(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata);
         if (!vecs[i].we) check($sformatf("vec%0d", i), last_rdata, vecs[i].exp);
      end

      // Ch0 periodic, LOAD=3: expiry on edges 4, 8, 12 after enable
      wr(32'h04, 32'd3);
      wr(32'h00, 32'h5);
      for (int k = 1; k <= 7; k++) begin
         rd(32'h08, 32'(3 - ((k - 1) % 4)), "ch0_count");
         check("ch0_irq", {31'b0, irq_o}, (k >= 5) ? 32'd1 : 32'd0);
      end
      wr(32'h0C, 32'h1);
      check("irq_at_race", {31'b0, irq_o}, 32'd1);
      rd(32'h0C, 32'h1, "w1c_vs_set");
      check("irq_after_race", {31'b0, irq_o}, 32'd1);
      check("irq_ch_after_race", {28'b0, irq_ch_o}, 32'h1);
      wr(32'h0C, 32'h1);
      rd(32'h0C, 32'h0, "ch0_w1c");
      check("irq_after_w1c", {31'b0, irq_o}, 32'd0);
      rd(32'h0C, 32'h0, "ch0_status_pre");
      rd(32'h0C, 32'h1, "ch0_repeat");
      wr(32'h00, 32'h0);
      rd(32'h0C, 32'h1, "pend_after_disable");
      wr(32'h0C, 32'h1);
      rd(32'h08, 32'd1, "count_frozen");
      idle(3);
      rd(32'h08, 32'd1, "count_still_frozen");
      check("irq_idle", {31'b0, irq_o}, 32'd0);

      // Ch1 one-shot, LOAD=2, PSC=4
      wr(32'h14, 32'd2);
      wr(32'h10, 32'h0004_0003);
      expect_expiry(32'h1C, PSC_ON ? 15 : 3, PSC_ON ? 20 : 8, "ch1_oneshot");
      rd(32'h10, PSC_ON ? 32'h0004_0002 : 32'h2, "ch1_en_cleared");
      rd(32'h18, 32'h0, "ch1_count_hold");
      wr(32'h1C, 32'h1);
      for (int k = 0; k < 10; k++) rd(32'h1C, 32'h0, "ch1_no_repend");
      check("ch1_no_irq", {31'b0, irq_o}, 32'd0);

      // Ch3 LOAD=0 periodic: PEND on every tick, so W1C cannot clear it
      wr(32'h34, 32'h0);
      wr(32'h30, 32'h5);
      idle(2);
      wr(32'h3C, 32'h1);
      rd(32'h3C, 32'h1, "load0_pend");

      // Ch2 counting down from 200, async reset mid-read at COUNT=100
      wr(32'h24, 32'd200);
      wr(32'h20, 32'h5);
      idle(100);
      rd(32'h28, 32'd100, "ch2_count100");
      check("irq_before_rst", {31'b0, irq_o}, 32'd1);
      req_i  = 1'b1;
      we_i   = 1'b0;
      be_i   = 4'hF;
      addr_i = 32'h28;
      #2;
      rst_i = 1'b1;
      #1;
      check("rst_async_rvalid", {31'b0, rvalid_o}, 32'd0);
      check("rst_async_data", data_o, 32'h0);
      check("rst_async_irq", {31'b0, irq_o}, 32'd0);
      check("rst_async_irq_ch", {28'b0, irq_ch_o}, 32'h0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      req_i = 1'b0;
      be_i  = 4'h0;
      for (int a = 32'h20; a < 32'h40; a += 4) rd(32'(a), 32'h0, "post_rst_reg");
      idle(5);
      rd(32'h28, 32'h0, "post_rst_no_tick");
      rd(32'h2C, 32'h0, "post_rst_no_pend");
      check("post_rst_irq", {31'b0, irq_o}, 32'd0);

      // Ch1 one-shot, LOAD=1, PSC=7
      wr(32'h14, 32'd1);
      wr(32'h10, 32'h0007_0003);
      expect_expiry(32'h1C, PSC_ON ? 16 : 2, PSC_ON ? 20 : 6, "psc7_expiry");
      rd(32'h10, PSC_ON ? 32'h0007_0002 : 32'h2, "psc7_ctrl");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/timer_multi.md
TIMER_MULTI -- requirements
Module: timer_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent timer channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32: counter and LOAD width in bits (8..32).
REQ-003 SHALL have parameter PSC_W, default 16: prescaler width in bits (1..16).
REQ-004 SHALL have port clk_i, input, 1: the single clock.
REQ-005 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have ports req_i/we_i, input, 1/1: OBI request and write-enable.
REQ-007 SHALL have ports be_i/addr_i/data_i, input, 4/32/32: OBI byte enables, address and write data.
REQ-008 SHALL have ports gnt_o/rvalid_o, output, 1/1: OBI grant and response-valid.
REQ-009 SHALL have port data_o, output, 32: OBI read data.
REQ-010 SHALL have port irq_ch_o, output, NUM_CH: per-channel interrupt, pending AND IE.
REQ-011 SHALL have port irq_o, output, 1: OR of irq_ch_o.

Function
REQ-012 SHALL drive gnt_o = req_i combinationally; rvalid_o SHALL be asserted exactly one cycle after each granted request, reads and writes alike.
REQ-013 SHALL decode only addr_i[15:0]; channel n SHALL occupy offsets 0x10*n + {0x0 CTRL, 0x4 LOAD, 0x8 COUNT, 0xC STATUS}.
REQ-014 CTRL fields SHALL be bit0 EN, bit1 MODE (0 periodic, 1 one-shot), bit2 IE, bits[16+PSC_W-1:16] PSC; all other bits read 0.
REQ-015 Writes to CTRL/LOAD SHALL honour be_i per byte; COUNT SHALL be read-only; STATUS bit0 PEND SHALL be write-1-to-clear.
REQ-016 Reads SHALL return the register value sampled in the request cycle, registered onto data_o; unmapped offsets and channels >= NUM_CH SHALL read 0 and ignore writes.
REQ-017 A tick SHALL occur when EN=1 and the prescaler equals PSC; the prescaler SHALL then return to 0, otherwise increment; PSC=0 SHALL give a tick every cycle.
REQ-018 On a tick with COUNT != 0, COUNT SHALL decrement by 1.
REQ-019 On a tick with COUNT == 0, PEND SHALL set; periodic mode SHALL reload COUNT from LOAD; one-shot mode SHALL clear EN and hold COUNT at 0.
REQ-020 An EN 0->1 write SHALL load COUNT from LOAD and clear the prescaler in the same edge; it SHALL NOT tick that cycle.
REQ-021 LOAD=0 in periodic mode SHALL set PEND on every tick.
REQ-022 A same-cycle PEND set and W1C SHALL leave PEND=1 (set wins).
REQ-023 A same-cycle tick and LOAD write SHALL update LOAD; any reload that cycle SHALL use the old LOAD value.
REQ-024 EN 1->0 SHALL freeze COUNT and prescaler; PEND SHALL be unaffected.
REQ-025 irq_ch_o/irq_o SHALL be registered, asserting one cycle after PEND&IE becomes true.

Reset
REQ-026 rst_i SHALL asynchronously clear all CTRL, LOAD, COUNT, PEND, prescalers, rvalid_o, data_o, irq_ch_o and irq_o to 0, including mid-count and mid-transaction.

Configuration
REQ-027 With TIMER_MULTI_PSC_EN defined, the prescaler SHALL be implemented per REQ-017.
REQ-028 Without TIMER_MULTI_PSC_EN, no prescaler flops SHALL exist, PSC SHALL read 0 and ignore writes, and every EN cycle SHALL be a tick.

Structure
REQ-029 Package timer_multi_pkg SHALL hold the register offsets, CTRL bit positions and the channel-stride constant.
REQ-030 Per-channel logic SHALL be sub-module timer_multi_ch, instantiated NUM_CH times by a generate loop; timer_multi SHALL hold the bus decode, read mux and IRQ OR.

Verification
REQ-031 Ch0: LOAD=3, PSC=0, CTRL=0x5 (EN, periodic, IE) -> PEND sets on the 4th tick, COUNT reloads to 3, irq_o high one cycle later, and this repeats every 4 cycles.
REQ-032 Ch1: LOAD=2, PSC=4, MODE=1 -> expiry after 15 cycles, EN reads 0, COUNT holds 0, and no further PEND is set after W1C.
REQ-033 PEND W1C issued in the same cycle as a new expiry -> STATUS reads 1 and irq_o stays high.
REQ-034 Read of 0x40 with NUM_CH=4 -> data_o=0 and rvalid_o one cycle after req_i; a write with be_i=0x1 to LOAD=0xFFFFFFFF changes only LOAD[7:0].
REQ-035 rst_i pulsed while ch2 is counting with COUNT=100 -> all registers and irq_o read 0 immediately and no tick occurs after release.
REQ-036 Build without TIMER_MULTI_PSC_EN: write PSC=7 with LOAD=1 -> CTRL[31:16] reads 0 and expiry occurs after 2 cycles.
